// File: rtl/cg_vector_pingpong_mem_pkg.sv
// Shared sizing defaults, depth derivation and read FSM encoding for the
// CG vector ping-pong store.
package cg_vector_pingpong_mem_pkg;

    localparam int DEF_ELEMENT_WIDTH = 64;
    localparam int DEF_NO_OF_UNITS   = 8;
    localparam int DEF_NUM_EQUATIONS = 10;

    // Vector length rounded up to whole blocks (always adds padding lanes, even when N divides evenly).
    function automatic int calc_total(input int n, input int nu);
        return n + (nu - (n % nu));
    endfunction

    function automatic int calc_depth(input int n, input int nu);
        return calc_total(n, nu) / nu;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_SWAP   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/cg_vector_pingpong_mem_bank.sv
// One block-wide register bank: synchronous write, asynchronous read.
module cg_vector_pingpong_mem_bank #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 512,
    parameter int AW    = 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cg_vector_pingpong_mem.sv
// Double-buffered CG vector store: ALU results fill the NEW bank while the OLD
// bank streams back block by block; banks trade roles on a swap request.
module cg_vector_pingpong_mem
    import cg_vector_pingpong_mem_pkg::*;
#(
    parameter int NO_OF_UNITS                     = DEF_NO_OF_UNITS,
    parameter int NUMBER_OF_EQUATIONS_PER_CLUSTER = DEF_NUM_EQUATIONS,
    parameter int ELEMENT_WIDTH                   = DEF_ELEMENT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
    input  logic                                 load_en,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] load_data,
    input  logic                                 rd_start,
    input  logic                                 rd_ready,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data,
    output logic                                 rd_valid,
    output logic                                 rd_last,
    input  logic                                 swap_req,
    output logic                                 swap_done,
    output logic                                 wr_full,
    output logic                                 overflow_err,
    output logic                                 busy,
    output rd_state_t                            state_dbg,
    output logic                                 bank_sel_dbg
);

    localparam int W     = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam int DEPTH = calc_depth(NUMBER_OF_EQUATIONS_PER_CLUSTER, NO_OF_UNITS);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = $clog2(DEPTH + 1);

    // Read handshake: a block transfers on every rising edge where rd_valid && rd_ready;
    // rd_data/rd_last are registered and hold while rd_ready is low.

    rd_state_t        state, state_nx;
    logic             bank_sel;   // 0: bank0 OLD, bank1 NEW
    logic             swap_pend;
    logic [PTR_W-1:0] wr_ptr, load_ptr;
    logic [AW-1:0]    rd_ptr, rd_addr;
    logic             swap_exec, start_ok, hs;
    logic             wr_we, load_we, load_ovf;
    logic [W-1:0]     bank0_rd, bank1_rd, old_rd;

    always_comb begin
        state_nx  = state;
        swap_exec = 1'b0;
        start_ok  = 1'b0;
        hs        = rd_valid && rd_ready;
        case (state)
            ST_IDLE: begin
                // A pending swap takes precedence; a coincident rd_start is dropped.
                if (swap_pend) begin
                    swap_exec = 1'b1;
                end else if (rd_start) begin
                    start_ok = 1'b1;
                    state_nx = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (hs && rd_last) begin
                    state_nx = swap_pend ? ST_SWAP : ST_IDLE;
                end
            end
            ST_SWAP: begin
                swap_exec = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign wr_we    = wr_en && (wr_ptr < PTR_W'(DEPTH));
    assign load_we  = load_en && (state == ST_IDLE) && (load_ptr < PTR_W'(DEPTH));
    assign load_ovf = load_en && (state == ST_IDLE) && (load_ptr == PTR_W'(DEPTH));
    assign rd_addr  = start_ok ? AW'(0) : rd_ptr + AW'(1);

    cg_vector_pingpong_mem_bank #(.DEPTH(DEPTH), .WIDTH(W), .AW(AW)) u_bank0 (
        .clk   (clk),
        .we    (bank_sel ? wr_we : load_we),
        .waddr (bank_sel ? wr_ptr[AW-1:0] : load_ptr[AW-1:0]),
        .wdata (bank_sel ? wr_data : load_data),
        .raddr (rd_addr),
        .rdata (bank0_rd)
    );

    cg_vector_pingpong_mem_bank #(.DEPTH(DEPTH), .WIDTH(W), .AW(AW)) u_bank1 (
        .clk   (clk),
        .we    (bank_sel ? load_we : wr_we),
        .waddr (bank_sel ? load_ptr[AW-1:0] : wr_ptr[AW-1:0]),
        .wdata (bank_sel ? load_data : wr_data),
        .raddr (rd_addr),
        .rdata (bank1_rd)
    );

    assign old_rd = bank_sel ? bank1_rd : bank0_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            bank_sel     <= 1'b0;
            swap_pend    <= 1'b0;
            swap_done    <= 1'b0;
            wr_ptr       <= '0;
            load_ptr     <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= '0;
        end else begin
            state     <= state_nx;
            swap_done <= swap_exec;

            if (swap_exec) begin
                bank_sel  <= ~bank_sel;
                swap_pend <= 1'b0;
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end

            // A write landing in the swap cycle still targets the pre-swap NEW bank.
            if (swap_exec) begin
                wr_ptr   <= '0;
                load_ptr <= '0;
            end else begin
                if (wr_we)   wr_ptr   <= wr_ptr + PTR_W'(1);
                if (load_we) load_ptr <= load_ptr + PTR_W'(1);
            end

            if ((wr_en && !wr_we) || load_ovf) begin
                overflow_err <= 1'b1;
            end

            if (start_ok) begin
                rd_valid <= 1'b1;
                rd_ptr   <= '0;
                rd_data  <= old_rd;
                rd_last  <= (rd_addr == AW'(DEPTH - 1));
            end else if ((state == ST_STREAM) && hs) begin
                if (rd_last) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end else begin
                    rd_ptr  <= rd_addr;
                    rd_data <= old_rd;
                    rd_last <= (rd_addr == AW'(DEPTH - 1));
                end
            end
        end
    end

    assign wr_full      = (wr_ptr == PTR_W'(DEPTH));
    assign busy         = (state != ST_IDLE) || swap_pend;
    assign state_dbg    = state;
    assign bank_sel_dbg = bank_sel;

endmodule
